// File: rtl/issue_scoreboard.sv
// issue_scoreboard: register-hazard scoreboard with a single-entry issue register.
module issue_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [6:0]       dec_operation,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rw,
  input  logic             dec_write,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [6:0]       iss_operation,
  output logic [4:0]       iss_rs1,
  output logic [4:0]       iss_rs2,
  output logic [4:0]       iss_rw,
  output logic             iss_write,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rw,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [NREGS-1:0] wbm, fm, setm, busy_eff;
  logic hazard, accept;
  always_comb begin
    wbm = (wb_valid && wb_rw != '0) ? NREGS'(1) << wb_rw : '0;
    busy_eff = busy & ~wbm;
    hazard = (dec_rs1 != '0 && busy_eff[dec_rs1]) ||
             (dec_rs2 != '0 && busy_eff[dec_rs2]) ||
             (dec_write && dec_rw != '0 && busy_eff[dec_rw]);
    dec_ready = !hazard && !flush && (!iss_valid || iss_ready);
    accept = dec_valid && dec_ready;
    // a flushed writer solely owns its bit, so releasing it cannot free another writer's claim
    fm = (flush && iss_valid && iss_write && iss_rw != '0) ? NREGS'(1) << iss_rw : '0;
    setm = (accept && dec_write && dec_rw != '0) ? NREGS'(1) << dec_rw : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      iss_valid <= 1'b0;
      iss_operation <= '0;
      iss_rs1 <= '0;
      iss_rs2 <= '0;
      iss_rw <= '0;
      iss_write <= 1'b0;
      stall_cnt <= '0;
    end else begin
      busy <= (busy & ~wbm & ~fm) | setm;
      iss_valid <= flush ? 1'b0 : accept ? 1'b1 : iss_ready ? 1'b0 : iss_valid;
      if (accept) begin
        iss_operation <= dec_operation;
        iss_rs1 <= dec_rs1;
        iss_rs2 <= dec_rs2;
        iss_rw <= dec_rw;
        iss_write <= dec_write;
      end
      if (dec_valid && hazard && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed scenarios plus randomized traffic against a behavioural model.
module tb_issue_scoreboard;
  logic clk = 0, rst_n = 1;
  logic dec_valid = 0, dec_ready, dec_write = 0;
  logic [6:0] dec_operation = 0;
  logic [4:0] dec_rs1 = 0, dec_rs2 = 0, dec_rw = 0;
  logic iss_valid, iss_ready = 0, iss_write;
  logic [6:0] iss_operation;
  logic [4:0] iss_rs1, iss_rs2, iss_rw;
  logic wb_valid = 0, flush = 0;
  logic [4:0] wb_rw = 0;
  logic [31:0] busy;
  logic [3:0] stall_cnt;
  int checks = 0, errors = 0;

  issue_scoreboard #(.NREGS(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_operation(dec_operation), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rw(dec_rw),
    .dec_write(dec_write), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_operation(iss_operation), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rw(iss_rw),
    .iss_write(iss_write), .wb_valid(wb_valid), .wb_rw(wb_rw), .flush(flush),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // reference model: a set of pending destination registers and one issue slot
  bit mb[32];
  bit mv;
  logic [6:0] mop;
  logic [4:0] m1, m2, mw;
  logic mwr;
  int mcnt;

  function automatic bit m_pending(logic [4:0] r);
    return r != 0 && mb[r] && !(wb_valid && wb_rw == r);
  endfunction
  function automatic bit m_hazard();
    return m_pending(dec_rs1) || m_pending(dec_rs2) || (dec_write && m_pending(dec_rw));
  endfunction
  function automatic bit m_ready();
    return !m_hazard() && !flush && (!mv || iss_ready);
  endfunction
  function automatic logic [31:0] m_busy();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mb[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit hz, acc;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mb[i] = 0;
      mv = 0; mop = 0; m1 = 0; m2 = 0; mw = 0; mwr = 0; mcnt = 0;
    end else begin
      hz = m_hazard();
      acc = dec_valid && m_ready();
      if (dec_valid && hz && !flush) mcnt = (mcnt < 15) ? mcnt + 1 : 15;
      if (wb_valid && wb_rw != 0) mb[wb_rw] = 0;
      if (flush && mv && mwr && mw != 0) mb[mw] = 0;
      if (flush) mv = 0;
      else if (acc) begin
        mv = 1; mop = dec_operation; m1 = dec_rs1; m2 = dec_rs2; mw = dec_rw; mwr = dec_write;
        if (dec_write && dec_rw != 0) mb[dec_rw] = 1;
      end else if (iss_ready) mv = 0;
    end
  end

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rw, input logic w, input logic ir, input logic wbv,
                       input logic [4:0] wbr, input logic fl);
    dec_valid = v; dec_operation = op; dec_rs1 = r1; dec_rs2 = r2; dec_rw = rw; dec_write = w;
    iss_ready = ir; wb_valid = wbv; wb_rw = wbr; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy); end
    checks++;
    if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
    checks++;
    if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    checks++;
    if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_dec_ready: got %b want 1", dec_ready); end
    checks++;
    drive(1, 7'h13, 0, 0, 5, 1, 0, 0, 0, 0);
    tick();
    drive(1, 7'h33, 5, 0, 0, 0, 0, 0, 0, 0);
    tick();
    if (busy !== 32'h20 || iss_valid !== 1'b1 || stall_cnt !== 4'd1) begin
      errors++; $display("FAIL pre_reset_state: got busy=%h v=%b cnt=%0d want 20 1 1", busy, iss_valid, stall_cnt);
    end
    checks++;
    #2 rst_n = 0;
    #1;
    if (busy !== 32'h0 || iss_valid !== 1'b0 || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL async_reset: got busy=%h v=%b cnt=%0d want 0 0 0", busy, iss_valid, stall_cnt);
    end
    checks++;
    if ({iss_operation, iss_rs1, iss_rs2, iss_rw, iss_write} !== 23'h0) begin
      errors++; $display("FAIL async_reset_payload: got op=%h rw=%0d want 0", iss_operation, iss_rw);
    end
    checks++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1;
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 7'(i), 0, 0, 5'(i), 1, 1, 0, 0, 0);
      #1;
      if (dec_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b want 1", i, dec_ready); end
      checks++;
      tick();
      if (iss_valid !== 1'b1 || iss_rw !== 5'(i)) begin
        errors++; $display("FAIL stream_issue%0d: got v=%b rw=%0d want 1 %0d", i, iss_valid, iss_rw, i);
      end
      checks++;
    end
    if (busy !== 32'h1E) begin errors++; $display("FAIL stream_busy: got %h want 1e", busy); end
    checks++;
  endtask

  task automatic test_raw();
    do_reset();
    drive(1, 7'h03, 0, 0, 5, 1, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 7'h33, 5, 0, 6, 1, 1, 0, 0, 0);
      #1;
      if (dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall%0d: got %b want 0", i, dec_ready); end
      checks++;
      tick();
    end
    if (stall_cnt !== 4'd3) begin errors++; $display("FAIL raw_stall_cnt: got %0d want 3", stall_cnt); end
    checks++;
    drive(1, 7'h33, 5, 0, 6, 1, 1, 1, 5, 0);
    #1;
    if (dec_ready !== 1'b1) begin errors++; $display("FAIL raw_bypass_ready: got %b want 1", dec_ready); end
    checks++;
    tick();
    if (busy !== 32'h40 || iss_rs1 !== 5'd5 || iss_valid !== 1'b1) begin
      errors++; $display("FAIL raw_after_wb: got busy=%h rs1=%0d v=%b want 40 5 1", busy, iss_rs1, iss_valid);
    end
    checks++;
  endtask

  task automatic test_waw();
    do_reset();
    drive(1, 7'h03, 0, 0, 7, 1, 1, 0, 0, 0);
    tick();
    drive(1, 7'h13, 0, 0, 7, 1, 1, 0, 0, 0);
    #1;
    if (dec_ready !== 1'b0) begin errors++; $display("FAIL waw_stall: got %b want 0", dec_ready); end
    checks++;
    tick();
    drive(1, 7'h13, 0, 0, 7, 1, 1, 1, 7, 0);
    #1;
    if (dec_ready !== 1'b1) begin errors++; $display("FAIL waw_ready: got %b want 1", dec_ready); end
    checks++;
    tick();
    if (busy !== 32'h80 || iss_valid !== 1'b1) begin
      errors++; $display("FAIL waw_set_wins: got busy=%h v=%b want 80 1", busy, iss_valid);
    end
    checks++;
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 7'h03, 0, 0, 9, 1, 0, 0, 0, 0);
    tick();
    drive(1, 7'h13, 0, 0, 3, 1, 0, 0, 0, 1);
    #1;
    if (dec_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", dec_ready); end
    checks++;
    tick();
    if (iss_valid !== 1'b0 || busy !== 32'h0) begin
      errors++; $display("FAIL flush_clear: got v=%b busy=%h want 0 0", iss_valid, busy);
    end
    checks++;
  endtask

  task automatic test_x0_sat();
    do_reset();
    drive(1, 7'h13, 0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    if (busy !== 32'h0 || iss_valid !== 1'b1) begin
      errors++; $display("FAIL x0_busy: got busy=%h v=%b want 0 1", busy, iss_valid);
    end
    checks++;
    drive(1, 7'h13, 0, 0, 2, 1, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1, 7'h33, 0, 2, 0, 0, 1, 0, 0, 0);
      tick();
    end
    if (stall_cnt !== 4'd15) begin errors++; $display("FAIL stall_saturate: got %0d want 15", stall_cnt); end
    checks++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 19) == 0));
      #1;
      if (dec_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, dec_ready, m_ready()); end
      checks++;
      if (busy !== m_busy()) begin errors++; $display("FAIL rnd_busy@%0d: got %h want %h", n, busy, m_busy()); end
      checks++;
      if (iss_valid !== mv || stall_cnt !== 4'(mcnt)) begin
        errors++; $display("FAIL rnd_state@%0d: got v=%b cnt=%0d want %b %0d", n, iss_valid, stall_cnt, mv, mcnt);
      end
      checks++;
      if ({iss_operation, iss_rs1, iss_rs2, iss_rw, iss_write} !== {mop, m1, m2, mw, mwr}) begin
        errors++; $display("FAIL rnd_payload@%0d: got %h want %h", n,
          {iss_operation, iss_rs1, iss_rs2, iss_rw, iss_write}, {mop, m1, m2, mw, mwr});
      end
      checks++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_raw();
    test_waw();
    test_flush();
    test_x0_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register-hazard scoreboard and single-entry issue stage placed directly after the instruction decoder. It accepts decoded fields (opcode, rs1, rs2, rw, write) through a valid/ready handshake and tracks which architectural registers have a write in flight. Instructions with RAW or WAW hazards are stalled until writeback clears the hazard. Hazard-free instructions are presented to execute through a registered valid/ready output.

## Interface
- NREGS, 32: architectural register count; index width is fixed at 5 bits, and x0 is hardwired zero.
- CNT_W, 16: width of the stall-cycle counter.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decoded instruction present.
- dec_ready  out  1  issue stage accepts this cycle.
- dec_operation  in  7  opcode.
- dec_rs1, dec_rs2  in  5 each  source register indices.
- dec_rw  in  5  destination register index.
- dec_write  in  1  instruction writes dec_rw.
- iss_valid  out  1  issue register holds an instruction.
- iss_ready  in  1  execute consumes the issue register.
- iss_operation  out  7; iss_rs1, iss_rs2, iss_rw  out  5 each; iss_write  out  1  registered copy of the accepted fields.
- wb_valid  in  1  writeback completes.
- wb_rw  in  5  register written back.
- flush  in  1  kill the instruction in the issue register.
- busy  out  NREGS  scoreboard bits; bit 0 is always 0.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Writeback mask: wbm = (wb_valid && wb_rw != 0) ? onehot(wb_rw) : 0.
- Effective busy: busy_eff = busy & ~wbm. Writeback clears a bit for the hazard check in the same cycle it arrives.
- Hazard is true if any of the following holds:
  - rs1 != 0 and busy_eff[rs1];
  - rs2 != 0 and busy_eff[rs2];
  - dec_write and rw != 0 and busy_eff[rw] (WAW).
- Both sources are always checked, regardless of opcode.
- dec_ready = !hazard && !flush && (!iss_valid || iss_ready). It is combinational from the dec_* payload, busy, wb_* and iss_ready. It does not depend on dec_valid.
- accept = dec_valid && dec_ready.
- On accept:
  - load the issue register from dec_*; iss_valid becomes 1;
  - if dec_write and rw != 0, set busy[rw].
- Else if iss_valid && iss_ready: iss_valid becomes 0; the payload holds its stale value.
- flush:
  - iss_valid becomes 0;
  - if the flushed entry has iss_write and iss_rw != 0, busy[iss_rw] is cleared;
  - no accept occurs that cycle.
  - WAW stalling guarantees that the flushed entry solely owns that bit.
- Writeback clears busy[wb_rw]. A writeback to a non-busy register or to x0 is ignored.
- Simultaneous set and clear of the same register (writeback frees r while a new writer of r is accepted): set wins, so busy[r] = 1.
- Flush and writeback in the same cycle: both clears apply.
- Issue register state: EMPTY (iss_valid = 0) and FULL (iss_valid = 1).
  - EMPTY → FULL on accept.
  - FULL → FULL on accept together with iss_ready.
  - FULL → EMPTY on iss_ready without accept, or on flush.
- stall_cnt increments each cycle that dec_valid && hazard && !flush. It saturates at 2^CNT_W−1. It does not count backpressure-only stalls (iss_valid && !iss_ready).

## Timing
- Reset (async assert) forces immediately: busy = 0, iss_valid = 0, all iss_* payload = 0, stall_cnt = 0. dec_ready then follows combinationally. Deassertion is synchronized externally.
- Reset mid-operation discards all in-flight state. No writeback is required afterwards.
- Latency: an instruction accepted at edge N shows iss_valid = 1 after edge N (1 cycle).
- Throughput: 1 instruction per cycle with iss_ready = 1 and no hazards.
- Dependent pair: the consumer is accepted in the same cycle as the producer's wb_valid, because the writeback bypass uses busy_eff.
- busy updates are visible on the output the cycle after the edge that sets or clears them.

## Test plan
- Reset: assert rst_n = 0 mid-stream with iss_valid = 1 and busy = 0x20 → busy = 0, iss_valid = 0, stall_cnt = 0 without a clock edge.
- Streaming: 4 independent instructions (rw = 1..4, sources x0), iss_ready = 1 → dec_ready = 1 every cycle, iss_valid continuous, busy = 0x1E after 4 cycles.
- RAW: writer rw = 5, then reader rs1 = 5; assert wb_valid with wb_rw = 5 three cycles later → reader stalls 3 cycles with stall_cnt = 3, is accepted in the wb cycle, busy[5] = 0.
- WAW with set-wins: busy[7] = 1; new writer rw = 7 arrives while wb_rw = 7 in the same cycle → accepted, busy[7] remains 1.
- Flush: entry rw = 9 sits in issue with iss_ready = 0, then flush → iss_valid = 0, busy[9] = 0, no accept that cycle.
- x0 and saturation: writer rw = 0 → busy stays 0. With CNT_W = 4, 20 hazard cycles → stall_cnt = 15.
